// File: rtl/btn_cond_pkg.sv
// -----------------------------------------------------------------------------
// btn_cond_pkg
// Shared types and defaults for the push-button conditioner.
//   btn_state_e               : debounce FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES   : stable cycles before a change is accepted (1 ms @ 50 MHz)
//   DEFAULT_LONG_PRESS_CYCLES : accepted-press cycles before a long-press event (1 s @ 50 MHz)
//   is_pressed_state()        : true for the states in which the debounced level is "pressed"
// -----------------------------------------------------------------------------
package btn_cond_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 50000;
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50000000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_e;

    // A release that is still being debounced is still a press.
    function automatic logic is_pressed_state(input btn_state_e st);
        return (st == PRESSED) || (st == DEB_RELEASE);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// btn_conditioner_if
// Bundles the raw button pin and the conditioned level/event outputs.
//   btn_raw_n         : board push-button, low = pressed
//   btn_level         : debounced level, high = pressed
//   btn_press_pulse   : one-cycle pulse per accepted press
//   btn_release_pulse : one-cycle pulse per accepted release
//   btn_long_pulse    : one-cycle pulse when a press has been held long enough
// Modports:
//   master : the conditioner (samples the pin, drives level and events)
//   slave  : the board/consumer side (drives the pin, observes level and events)
// -----------------------------------------------------------------------------
interface btn_conditioner_if;

    logic btn_raw_n;
    logic btn_level;
    logic btn_press_pulse;
    logic btn_release_pulse;
    logic btn_long_pulse;

    modport master (
        input  btn_raw_n,
        output btn_level,
        output btn_press_pulse,
        output btn_release_pulse,
        output btn_long_pulse
    );

    modport slave (
        output btn_raw_n,
        input  btn_level,
        input  btn_press_pulse,
        input  btn_release_pulse,
        input  btn_long_pulse
    );

endinterface

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
// Two-flop, 1-bit synchroniser for the asynchronous active-low button pin.
// Both flops reset to the released level (1) so a reset never looks like a press.
// Ports:
//   clk_clk       : system clock
//   reset_reset_n : synchronous active-low reset
//   d_n           : asynchronous input, low = pressed
//   q_n           : synchronised output, low = pressed
// -----------------------------------------------------------------------------
module btn_sync (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic d_n,
    output logic q_n
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the two stages into one.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_n;
            sync_q <= meta_q;
        end
    end

    assign q_n = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Debounces a board push-button and produces a clean level plus one-cycle
// press / release / long-press events.
// Parameters:
//   DEBOUNCE_CYCLES   : cycles the synchronised input must stay stable (>= 1)
//   LONG_PRESS_CYCLES : cycles of accepted press before the long-press event (>= 1)
// Ports:
//   clk_clk           : system clock (shared with the Nios system)
//   reset_reset_n     : synchronous active-low reset
//   btn_raw_n         : asynchronous button pin, low = pressed
//   btn_level         : registered debounced level, high = pressed
//   btn_press_pulse   : one-cycle pulse per accepted press
//   btn_release_pulse : one-cycle pulse per accepted release
//   btn_long_pulse    : one-cycle pulse when a press reaches LONG_PRESS_CYCLES
// Build option:
//   BTN_COND_LONG_PRESS_EN : when defined, the hold counter and long-press
//                            event are built; otherwise btn_long_pulse is 0.
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic btn_raw_n,
    output logic btn_level,
    output logic btn_press_pulse,
    output logic btn_release_pulse,
    output logic btn_long_pulse
);

    if (DEBOUNCE_CYCLES == 0 || LONG_PRESS_CYCLES == 0) begin : g_param_check
        $error("btn_conditioner: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
    end

    // One spare bit so the counter can never wrap within its legal range.
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Synchroniser: s is high while the (synchronised) button is pressed.
    // -------------------------------------------------------------------------
    logic btn_sync_n;
    logic btn_s;

    btn_sync u_sync (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .d_n           (btn_raw_n),
        .q_n           (btn_sync_n)
    );

    assign btn_s = ~btn_sync_n;

    // -------------------------------------------------------------------------
    // Debounce FSM
    // -------------------------------------------------------------------------
    btn_state_e       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // NOTE: every signal written here gets its default first, so no path
    // through the case statement leaves a value unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Level and press/release events.
    // The outputs are registered from the current state, one edge after the
    // FSM transition. level_q therefore holds the "pressed" view of the
    // previous state, and comparing it to the current state isolates the two
    // accepting transitions: PRESSED is only entered with level_q low from
    // DEB_PRESS, IDLE only with level_q high from DEB_RELEASE.
    // -------------------------------------------------------------------------
    logic level_q,   level_d;
    logic press_q,   press_d;
    logic release_q, release_d;

    always_comb begin
        level_d   = is_pressed_state(state_q);
        press_d   = (state_q == PRESSED) && !level_q;
        release_d = (state_q == IDLE)    &&  level_q;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level         = level_q;
    assign btn_press_pulse   = press_q;
    assign btn_release_pulse = release_q;

    // -------------------------------------------------------------------------
    // Long-press detection
    // -------------------------------------------------------------------------
`ifdef BTN_COND_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_ev_q,  long_ev_d;
    logic              long_q,     long_d;

    // The hold counter restarts only on a freshly accepted press; a rejected
    // release bounce (DEB_RELEASE -> PRESSED) resumes it. It saturates at
    // LONG_PRESS_CYCLES, so the event can fire at most once per press.
    // long_ev_q mirrors the FSM-transition edge and long_q is the output
    // stage, giving the long event the same pipeline depth as the others.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_ev_d  = 1'b0;
        long_d     = long_ev_q;
        if (state_q == DEB_PRESS && state_d == PRESSED) begin
            hold_cnt_d = '0;
        end else if (state_q == PRESSED && hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            long_ev_d  = (hold_cnt_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            hold_cnt_q <= '0;
            long_ev_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_ev_q  <= long_ev_d;
            long_q     <= long_d;
        end
    end

    assign btn_long_pulse = long_q;
`else
    assign btn_long_pulse = 1'b0;
`endif

endmodule
